// File: rtl/sdram_arbit.sv
// Central SDRAM bus arbiter: holds the init engine on the pins until init completes,
// then grants the shared bus to refresh / write / read with a per-grant watchdog.
module sdram_arbit #(
  parameter logic [9:0] TIMEOUT = 10'd1000,
  parameter logic [3:0] NOP_CMD = 4'b0111
) (
  input  logic        arb_clk,
  input  logic        arb_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic [1:0]  init_bank,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic [1:0]  aref_bank,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        arb_timeout
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant_wr;
  logic [9:0]  wd_cnt;
  logic        in_grant;
  logic        grant_end;
  logic        wd_expire;
  logic [3:0]  cmd;

  always_comb begin
    in_grant  = 1'b0;
    grant_end = 1'b0;
    case (state)
      AREF:  begin in_grant = 1'b1; grant_end = aref_end; end
      WRITE: begin in_grant = 1'b1; grant_end = wr_end;   end
      READ:  begin in_grant = 1'b1; grant_end = rd_end;   end
      default: ;
    endcase
    // A matching end pulse in the final watchdog cycle counts as a normal release.
    wd_expire = in_grant && (wd_cnt == TIMEOUT - 10'd1) && !grant_end;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        if (init_end) state_nxt = ARBIT;
      end
      ARBIT: begin
        if (aref_req)
          state_nxt = AREF;
        else if (wr_req && rd_req)
          state_nxt = last_grant_wr ? READ : WRITE;
        else if (wr_req)
          state_nxt = WRITE;
        else if (rd_req)
          state_nxt = READ;
      end
      AREF, WRITE, READ: begin
        if (grant_end || wd_expire) state_nxt = ARBIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state         <= INIT;
      last_grant_wr <= 1'b0;
      wd_cnt        <= '0;
      arb_timeout   <= 1'b0;
      sdram_cke     <= 1'b0;
    end else begin
      state     <= state_nxt;
      sdram_cke <= 1'b1;
      if (state == ARBIT && state_nxt == WRITE)
        last_grant_wr <= 1'b1;
      else if (state == ARBIT && state_nxt == READ)
        last_grant_wr <= 1'b0;
      // Grants always pass through ARBIT, so leaving a grant state also clears for the next entry.
      if (in_grant && state_nxt == state)
        wd_cnt <= wd_cnt + 10'd1;
      else
        wd_cnt <= '0;
      if (wd_expire)
        arb_timeout <= 1'b1;
    end
  end

  always_comb begin
    aref_en = (state == AREF);
    wr_en   = (state == WRITE);
    rd_en   = (state == READ);
  end

  always_comb begin
    cmd        = NOP_CMD;
    sdram_addr = '1;
    sdram_ba   = '1;
    if (arb_rst_n) begin
      case (state)
        INIT:  begin cmd = init_cmd; sdram_addr = init_addr; sdram_ba = init_bank; end
        AREF:  begin cmd = aref_cmd; sdram_addr = aref_addr; sdram_ba = aref_bank; end
        WRITE: begin cmd = wr_cmd;   sdram_addr = wr_addr;   sdram_ba = wr_bank;   end
        READ:  begin cmd = rd_cmd;   sdram_addr = rd_addr;   sdram_ba = rd_bank;   end
        default: ;
      endcase
    end
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  end

  always_comb begin
    sdram_dq_oe  = (state == WRITE) && wr_sdram_en;
    sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: behavioural engines, grant-order scoreboard and directed checks.
module tb_sdram_arbit;

  localparam int BURST = 5;

  logic        arb_clk;
  logic        arb_rst_n;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  logic [1:0]  init_bank;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic [1:0]  aref_bank;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_bank;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        aref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        arb_timeout;

  sdram_arbit #(
    .TIMEOUT(10'd16),
    .NOP_CMD(4'b0111)
  ) dut (
    .arb_clk(arb_clk), .arb_rst_n(arb_rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_bank(init_bank),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_bank(aref_bank),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .arb_timeout(arb_timeout)
  );

  initial begin
    arb_clk = 1'b0;
    forever #5 arb_clk = ~arb_clk;
  end

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard entries: grant code (1 aref, 2 write, 3 read) and required idle gap (-1 = any).
  typedef struct {
    int code;
    int gap;
  } exp_t;
  exp_t exp_q[$];

  function automatic void push_exp(input int code, input int gap);
    exp_t e;
    e.code = code;
    e.gap  = gap;
    exp_q.push_back(e);
  endfunction

  // Request bookkeeping: main raises *_todo, engines own *_done and the req/end pins.
  int   aref_todo = 0, wr_todo = 0, rd_todo = 0;
  int   aref_done = 0, wr_done = 0, rd_done = 0;
  logic rd_hang = 1'b0;

  initial begin
    int   cnt = 0;
    logic prev = 1'b0;
    aref_req = 1'b0; aref_end = 1'b0;
    forever begin
      @(posedge arb_clk); #2;
      aref_end = 1'b0;
      if (prev && !aref_en) aref_done++;
      prev = aref_en;
      if (aref_en) begin
        cnt++;
        if (cnt == BURST) begin aref_end = 1'b1; cnt = 0; end
      end else cnt = 0;
      aref_req = (aref_done < aref_todo);
    end
  end

  initial begin
    int   cnt = 0;
    logic prev = 1'b0;
    wr_req = 1'b0; wr_end = 1'b0;
    forever begin
      @(posedge arb_clk); #2;
      wr_end = 1'b0;
      if (prev && !wr_en) wr_done++;
      prev = wr_en;
      if (wr_en) begin
        cnt++;
        if (cnt == BURST) begin wr_end = 1'b1; cnt = 0; end
      end else cnt = 0;
      wr_req = (wr_done < wr_todo);
    end
  end

  initial begin
    int   cnt = 0;
    logic prev = 1'b0;
    rd_req = 1'b0; rd_end = 1'b0;
    forever begin
      @(posedge arb_clk); #2;
      rd_end = 1'b0;
      if (prev && !rd_en) rd_done++;
      prev = rd_en;
      if (rd_en) begin
        cnt++;
        if (!rd_hang && cnt == BURST) begin rd_end = 1'b1; cnt = 0; end
      end else cnt = 0;
      rd_req = (rd_done < rd_todo);
    end
  end

  // Monitor: on every new grant, pop the expected grant and check order, gap and pins.
  initial begin
    int   prev_g = 0;
    int   gap = 0;
    int   g;
    exp_t e;
    forever begin
      @(negedge arb_clk);
      g = aref_en ? 1 : wr_en ? 2 : rd_en ? 3 : 0;
      if (!arb_rst_n) begin
        prev_g = 0;
        gap    = 0;
      end else begin
        if (g != 0 && g != prev_g) begin
          check("grant_onehot", int'(aref_en) + int'(wr_en) + int'(rd_en), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_grant", g, 0);
          end else begin
            e = exp_q.pop_front();
            check("grant_order", g, e.code);
            if (e.gap >= 0) check("arbit_gap", gap, e.gap);
            case (e.code)
              1: begin
                check("aref_pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
                      {4'b0001, 2'b10, 13'h0aaa});
                check("aref_dq", {sdram_dq_oe, sdram_dq_out}, 17'h0);
              end
              2: begin
                check("wr_pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
                      {4'b0100, 2'b00, 13'h0123});
                check("wr_dq", {sdram_dq_oe, sdram_dq_out}, {1'b1, 16'hA5A5});
              end
              default: begin
                check("rd_pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
                      {4'b0101, 2'b01, 13'h0456});
                check("rd_dq", {sdram_dq_oe, sdram_dq_out}, 17'h0);
              end
            endcase
          end
        end
        gap    = (g == 0) ? gap + 1 : 0;
        prev_g = g;
      end
    end
  end

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || aref_en || wr_en || rd_en || aref_req || wr_req || rd_req) && n < bound) begin
      @(posedge arb_clk); #1;
      n++;
    end
    check(name, (n >= bound) ? 1 : 0, 0);
    repeat (3) @(posedge arb_clk);
    #1;
  endtask

  task automatic wait_grant(input string name, input int which, input int bound);
    int n = 0;
    while (!((which == 2 && wr_en) || (which == 3 && rd_en)) && n < bound) begin
      @(posedge arb_clk); #1;
      n++;
    end
    check(name, (n >= bound) ? 1 : 0, 0);
  endtask

  task automatic check_nop(input string name);
    check(name, {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {4'b0111, 2'b11, 13'h1fff});
  endtask

  initial begin
    int n;
    arb_rst_n     = 1'b0;
    init_end      = 1'b0;
    init_cmd      = 4'b0010; init_addr = 13'h0400; init_bank = 2'b01;
    aref_cmd      = 4'b0001; aref_addr = 13'h0aaa; aref_bank = 2'b10;
    wr_cmd        = 4'b0100; wr_addr   = 13'h0123; wr_bank   = 2'b00;
    rd_cmd        = 4'b0101; rd_addr   = 13'h0456; rd_bank   = 2'b01;
    wr_sdram_en   = 1'b1;
    wr_sdram_data = 16'hA5A5;

    // Reset values
    repeat (3) @(posedge arb_clk);
    #1;
    check("rst_cke", sdram_cke, 0);
    check("rst_grants", {aref_en, wr_en, rd_en}, 0);
    check_nop("rst_pins");
    check("rst_dq", {sdram_dq_oe, sdram_dq_out}, 0);
    check("rst_timeout", arb_timeout, 0);

    // Init phase: pins follow the init bus for 50 cycles
    arb_rst_n = 1'b1;
    @(posedge arb_clk); #1;
    check("init_cke", sdram_cke, 1);
    check("init_pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {4'b0010, 2'b01, 13'h0400});
    repeat (48) @(posedge arb_clk);
    #1;
    check("init_pins_late", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 4'b0010);
    check("init_grants", {aref_en, wr_en, rd_en}, 0);
    init_end = 1'b1;
    @(posedge arb_clk); #1;
    check_nop("arbit_pins");
    check("arbit_dq", {sdram_dq_oe, sdram_dq_out}, 0);

    // All three requests at once: refresh, then write (last_grant=read), then read
    push_exp(1, -1); push_exp(2, 1); push_exp(3, 1);
    aref_todo++; wr_todo++; rd_todo++;
    @(posedge arb_clk); #1;
    @(posedge arb_clk); #1;
    check("aref_latency", {aref_en, wr_en, rd_en}, 3'b100);
    wait_idle("idle_three_way", 200);

    // Write and read held high: strict alternation with one ARBIT cycle between
    push_exp(2, -1);
    for (int i = 0; i < 3; i++) begin push_exp(3, 1); push_exp(2, 1); end
    push_exp(3, 1);
    wr_todo += 4; rd_todo += 4;
    wait_idle("idle_alternate", 400);

    // Refresh arrives mid-write: no pre-emption, refresh then beats the pending read
    push_exp(2, -1); push_exp(1, 1); push_exp(3, 1);
    wr_todo++; rd_todo++;
    wait_grant("wait_wr_grant", 2, 50);
    @(posedge arb_clk); #1;
    aref_todo++;
    @(posedge arb_clk); #1;
    @(posedge arb_clk); #1;
    check("wr_not_preempted", {aref_en, wr_en, rd_en}, 3'b010);
    wait_idle("idle_preempt", 200);

    // Read engine never ends: watchdog releases after 16 cycles and flags sticky error
    rd_hang = 1'b1;
    push_exp(3, -1);
    rd_todo++;
    wait_grant("wait_rd_grant", 3, 50);
    n = 0;
    while (rd_en && n < 100) begin
      n++;
      @(posedge arb_clk); #1;
    end
    check("timeout_len", n, 16);
    check("timeout_flag", arb_timeout, 1);
    check_nop("timeout_pins");
    repeat (5) @(posedge arb_clk);
    #1;
    check("timeout_sticky", arb_timeout, 1);
    rd_hang = 1'b0;
    wait_idle("idle_timeout", 100);

    // Reset mid-grant: grants drop at once, flag clears
    push_exp(2, -1);
    wr_todo++;
    wait_grant("wait_wr_grant2", 2, 50);
    @(posedge arb_clk); #3;
    arb_rst_n = 1'b0;
    #1;
    check("midrst_grants", {aref_en, wr_en, rd_en}, 0);
    check_nop("midrst_pins");
    check("midrst_cke", sdram_cke, 0);
    check("midrst_timeout", arb_timeout, 0);
    check("midrst_dq", {sdram_dq_oe, sdram_dq_out}, 0);
    @(posedge arb_clk); #1;
    arb_rst_n = 1'b1;
    @(posedge arb_clk); #1;
    check("rerst_cke", sdram_cke, 1);
    wait_idle("idle_final", 50);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
